crossbar_2x2_scheduler: RTL and testbench
=========================================

Name: crossbar_2x2_scheduler

Overview:
- Upstream stage for the 2x2 4-bit crossbar: buffers packets from two source ports, resolves output contention, and produces registered crossbar inputs (in1, in2), a registered crossbar control, and per-output valid flags.
- Each packet is 4-bit data plus a 1-bit destination: 0 = out1, 1 = out2.
- The crossbar contract is fixed: control 0 routes straight (in1->out1, in2->out2); control 1 routes crossed (in1->out2, in2->out1).
- The crossbar is combinational and always accepts, so there is no downstream backpressure.

Parameters:
- DEPTH, 4: entries per input FIFO; must be a power of 2 and at least 2.
- DW, 4: data width; must match the crossbar width.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- s1_valid  input  1  source 1 offers a packet.
- s1_ready  output  1  source 1 FIFO not full.
- s1_data  input  DW  source 1 payload.
- s1_dest  input  1  source 1 destination (0 = out1, 1 = out2).
- s2_valid / s2_ready / s2_data / s2_dest: same as source 1, for source 2.
- xb_in1  output  DW  to crossbar in1.
- xb_in2  output  DW  to crossbar in2.
- xb_control  output  1  to crossbar control.
- out1_valid  output  1  crossbar out1 carries a granted packet this cycle.
- out2_valid  output  1  crossbar out2 carries a granted packet this cycle.

Behaviour:
- Accept: a push happens when sN_valid && sN_ready. sN_ready = !full, computed from the current count only, so a full FIFO refuses even if it pops in the same cycle. No bypass: a packet accepted in cycle t is a head candidate in cycle t+1 and appears on the outputs at t+2 at the earliest.
- Arbitration is combinational on the FIFO heads; a FIFO's head is a candidate when the FIFO is not empty.
  - Both heads present, different dests: both granted, both FIFOs pop. xb_control = head1.dest.
  - Only head1 present: granted, pops; xb_control = head1.dest.
  - Only head2 present: granted, pops; xb_control = ~head2.dest.
  - Both heads present, same dest (conflict): winner is in1 if prio==0, else in2. Only the winner pops; the loser holds its head. xb_control is set from the winner as above. prio toggles after every conflict and is unchanged otherwise.
  - Neither head present: no grant; xb_control holds its previous value.
- Registered outputs, updated the cycle after the grant:
  - xb_in1 = granted head1 data, else 0.
  - xb_in2 = granted head2 data, else 0.
  - outK_valid = 1 iff a granted packet is routed to outK.
- Reset values: xb_in1 = 0, xb_in2 = 0, xb_control = 0, out1_valid = 0, out2_valid = 0, prio = 0, both FIFOs empty (s1_ready = s2_ready = 1 in the cycle after reset). Reset mid-traffic discards all buffered packets.
- FIFO pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. count is log2(DEPTH)+1 bits wide; full = (count==DEPTH).
- Ordering: per-source FIFO order is preserved. There is no ordering guarantee between sources.

Optional Feature:
- Macro XBAR_SCHED_STATS_EN.
- Defined: adds output conflict_cnt (8 bits). It resets to 0, increments once per conflict cycle, and saturates at 255.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package/header holds:
  - localparams DEST_OUT1 = 1'b0, DEST_OUT2 = 1'b1, CTRL_STRAIGHT = 1'b0, CTRL_CROSS = 1'b1;
  - the packet field layout {dest, data}, width DW+1.
- One sub-module, sched_fifo: a synchronous FIFO of width DW+1 and depth DEPTH, with push, pop, head, full, empty and count. Instantiated twice.

Test Plan:
- Reset: assert rst 2 cycles with s1_valid=1 -> all outputs 0, no push; after release s1_ready=s2_ready=1.
- No conflict: s1 {dest=1, data=4'hA} and s2 {dest=0, data=4'h5} in the same cycle -> two cycles later xb_control=1, xb_in1=A, xb_in2=5, out1_valid=out2_valid=1.
- Conflict round-robin: s1 {0,3} and s2 {0,C}, then s1 {0,4} and s2 {0,D} -> grants in order: in1 (3), in2 (C), in1 (4), in2 (D). Each grant has out1_valid=1, out2_valid=0, and the ungranted lane's data is 0.
- Full: hold s1_valid=1 with s1_dest=0 while s2 continuously streams dest=0 -> s1_ready drops when count reaches DEPTH; no packet is lost or duplicated; a scoreboard matches per-source order.
- Single source: only s2 {dest=1, data=4'h7} -> xb_control=0, xb_in2=7, out2_valid=1, out1_valid=0.
- Mid-traffic reset: rst=1 for 1 cycle with both FIFOs holding 3 entries -> FIFOs empty, no stale output after reset, prio=0; with XBAR_SCHED_STATS_EN defined, conflict_cnt=0.

Source files
------------

// File: rtl/crossbar_2x2_scheduler_pkg.sv
// Shared constants for the 2x2 crossbar scheduler.
// Packet layout is {dest, data}: dest is the single bit directly above the DW data bits.
package crossbar_2x2_scheduler_pkg;

    localparam logic DEST_OUT1     = 1'b0;
    localparam logic DEST_OUT2     = 1'b1;
    localparam logic CTRL_STRAIGHT = 1'b0;
    localparam logic CTRL_CROSS    = 1'b1;

    localparam int STATS_W = 8;

    function automatic int pkt_w(input int dw);
        return dw + 1;
    endfunction

endpackage

// File: rtl/crossbar_2x2_scheduler_sched_fifo.sv
// Synchronous FIFO with a registered-memory head; push is ignored when full, pop when empty.
module sched_fifo
    import crossbar_2x2_scheduler_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/crossbar_2x2_scheduler.sv
// Two-source scheduler feeding a 2x2 crossbar: per-source FIFOs, round-robin conflict arbitration, registered outputs.
// Optional conflict statistics counter enabled by defining XBAR_SCHED_STATS_EN.
module crossbar_2x2_scheduler
    import crossbar_2x2_scheduler_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s1_valid,
    output logic          s1_ready,
    input  logic [DW-1:0] s1_data,
    input  logic          s1_dest,
    input  logic          s2_valid,
    output logic          s2_ready,
    input  logic [DW-1:0] s2_data,
    input  logic          s2_dest,
    output logic [DW-1:0] xb_in1,
    output logic [DW-1:0] xb_in2,
    output logic          xb_control,
    output logic          out1_valid,
    output logic          out2_valid
`ifdef XBAR_SCHED_STATS_EN
    ,
    output logic [STATS_W-1:0] conflict_cnt
`endif
);

    localparam int PW = pkt_w(DW);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [PW-1:0] head1;
    logic [PW-1:0] head2;
    logic          full1;
    logic          full2;
    logic          empty1;
    logic          empty2;
    logic [CW-1:0] count1;
    logic [CW-1:0] count2;
    logic          unused_counts;

    logic cand1;
    logic cand2;
    logic dest1;
    logic dest2;
    logic conflict;
    logic grant1;
    logic grant2;
    logic ctrl_next;
    logic prio;

    assign unused_counts = ^{count1, count2};

    sched_fifo #(.DEPTH(DEPTH), .W(PW)) u_fifo1 (
        .clk   (clk),
        .rst   (rst),
        .push  (s1_valid),
        .pop   (grant1),
        .din   ({s1_dest, s1_data}),
        .head  (head1),
        .full  (full1),
        .empty (empty1),
        .count (count1)
    );

    sched_fifo #(.DEPTH(DEPTH), .W(PW)) u_fifo2 (
        .clk   (clk),
        .rst   (rst),
        .push  (s2_valid),
        .pop   (grant2),
        .din   ({s2_dest, s2_data}),
        .head  (head2),
        .full  (full2),
        .empty (empty2),
        .count (count2)
    );

    assign s1_ready = !full1;
    assign s2_ready = !full2;

    always_comb begin
        cand1    = !empty1;
        cand2    = !empty2;
        dest1    = head1[DW];
        dest2    = head2[DW];
        conflict = cand1 && cand2 && (dest1 == dest2);
        grant1   = cand1 && !(conflict && prio);
        grant2   = cand2 && !(conflict && !prio);
        // The granted lane picks the control; with no grant the crossbar setting is held.
        ctrl_next = xb_control;
        if (grant1) begin
            ctrl_next = (dest1 == DEST_OUT2) ? CTRL_CROSS : CTRL_STRAIGHT;
        end else if (grant2) begin
            ctrl_next = (dest2 == DEST_OUT2) ? CTRL_STRAIGHT : CTRL_CROSS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xb_in1     <= '0;
            xb_in2     <= '0;
            xb_control <= CTRL_STRAIGHT;
            out1_valid <= 1'b0;
            out2_valid <= 1'b0;
            prio       <= 1'b0;
        end else begin
            xb_in1     <= grant1 ? head1[DW-1:0] : '0;
            xb_in2     <= grant2 ? head2[DW-1:0] : '0;
            xb_control <= ctrl_next;
            out1_valid <= (grant1 && dest1 == DEST_OUT1) || (grant2 && dest2 == DEST_OUT1);
            out2_valid <= (grant1 && dest1 == DEST_OUT2) || (grant2 && dest2 == DEST_OUT2);
            prio       <= prio ^ conflict;
        end
    end

`ifdef XBAR_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (conflict && (conflict_cnt != {STATS_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + STATS_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_crossbar_2x2_scheduler.sv
// Self-checking bench: directed literal checks plus randomized traffic against a queue-based model.
module tb_crossbar_2x2_scheduler;

    localparam int DEPTH = 4;
    localparam int DW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s1_valid = 1'b0;
    logic          s1_ready;
    logic [DW-1:0] s1_data = '0;
    logic          s1_dest = 1'b0;
    logic          s2_valid = 1'b0;
    logic          s2_ready;
    logic [DW-1:0] s2_data = '0;
    logic          s2_dest = 1'b0;
    logic [DW-1:0] xb_in1;
    logic [DW-1:0] xb_in2;
    logic          xb_control;
    logic          out1_valid;
    logic          out2_valid;
`ifdef XBAR_SCHED_STATS_EN
    logic [7:0]    conflict_cnt;
`endif

    crossbar_2x2_scheduler #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .s1_valid   (s1_valid),
        .s1_ready   (s1_ready),
        .s1_data    (s1_data),
        .s1_dest    (s1_dest),
        .s2_valid   (s2_valid),
        .s2_ready   (s2_ready),
        .s2_data    (s2_data),
        .s2_dest    (s2_dest),
        .xb_in1     (xb_in1),
        .xb_in2     (xb_in2),
        .xb_control (xb_control),
        .out1_valid (out1_valid),
        .out2_valid (out2_valid)
`ifdef XBAR_SCHED_STATS_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_dut_grants = 0;
    bit saw_full = 1'b0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: packets held as {dest,data} in per-source queues.
    logic [4:0] q1[$];
    logic [4:0] q2[$];
    bit         m_prio = 1'b0;
    logic [3:0] e_in1 = '0;
    logic [3:0] e_in2 = '0;
    logic       e_ctrl = 1'b0;
    logic       e_v1 = 1'b0;
    logic       e_v2 = 1'b0;
    logic       e_rdy1 = 1'b1;
    logic       e_rdy2 = 1'b1;
    logic [7:0] e_cc = '0;

    always @(posedge clk) begin : model
        logic [4:0] p1;
        logic [4:0] p2;
        logic h1, h2, a1, a2, cf, w1, w2;
        if (rst) begin
            q1.delete();
            q2.delete();
            m_prio = 1'b0;
            e_in1 = '0; e_in2 = '0; e_ctrl = 1'b0; e_v1 = 1'b0; e_v2 = 1'b0;
            e_rdy1 = 1'b1; e_rdy2 = 1'b1; e_cc = '0;
        end else begin
            h1 = (q1.size() != 0);
            h2 = (q2.size() != 0);
            p1 = h1 ? q1[0] : 5'd0;
            p2 = h2 ? q2[0] : 5'd0;
            a1 = s1_valid && (q1.size() < DEPTH);
            a2 = s2_valid && (q2.size() < DEPTH);
            cf = h1 && h2 && (p1[4] == p2[4]);
            w1 = h1 && (!cf || !m_prio);
            w2 = h2 && (!cf || m_prio);
            // Control chosen so the winning packet lands on its destination output.
            if (w1)      e_ctrl = p1[4];
            else if (w2) e_ctrl = !p2[4];
            e_in1 = w1 ? p1[3:0] : 4'h0;
            e_in2 = w2 ? p2[3:0] : 4'h0;
            // Straight: out1<-in1, out2<-in2; crossed: out1<-in2, out2<-in1.
            e_v1 = e_ctrl ? w2 : w1;
            e_v2 = e_ctrl ? w1 : w2;
            if (cf) begin
                m_prio = !m_prio;
                if (e_cc != 8'hFF) e_cc = e_cc + 8'd1;
            end
            if (w1) void'(q1.pop_front());
            if (w2) void'(q2.pop_front());
            if (a1) begin q1.push_back({s1_dest, s1_data}); n_acc++; end
            if (a2) begin q2.push_back({s2_dest, s2_data}); n_acc++; end
            e_rdy1 = (q1.size() < DEPTH);
            e_rdy2 = (q2.size() < DEPTH);
        end
    end

    always @(posedge clk) begin : compare
        #1;
        chk4("m_in1", xb_in1, e_in1);
        chk4("m_in2", xb_in2, e_in2);
        chk1("m_ctrl", xb_control, e_ctrl);
        chk1("m_v1", out1_valid, e_v1);
        chk1("m_v2", out2_valid, e_v2);
        chk1("m_rdy1", s1_ready, e_rdy1);
        chk1("m_rdy2", s2_ready, e_rdy2);
`ifdef XBAR_SCHED_STATS_EN
        chk8("m_cc", conflict_cnt, e_cc);
`endif
        n_dut_grants += int'(out1_valid === 1'b1) + int'(out2_valid === 1'b1);
        if (s1_ready === 1'b0) saw_full = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v1, input logic d1, input logic [3:0] x1,
                         input logic v2, input logic d2, input logic [3:0] x2);
        @(negedge clk);
        s1_valid = v1; s1_dest = d1; s1_data = x1;
        s2_valid = v2; s2_dest = d2; s2_data = x2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        // Reset held two cycles while source 1 offers a packet.
        rst = 1'b1; s1_valid = 1'b1; s1_dest = 1'b0; s1_data = 4'h9;
        tick(); tick();
        chk4("rst_in1", xb_in1, 4'h0);
        chk4("rst_in2", xb_in2, 4'h0);
        chk1("rst_ctrl", xb_control, 1'b0);
        chk1("rst_v1", out1_valid, 1'b0);
        chk1("rst_v2", out2_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0; s1_valid = 1'b0;
        tick();
        chk1("rst_rdy1", s1_ready, 1'b1);
        chk1("rst_rdy2", s2_ready, 1'b1);
        tick();
        chk1("rst_nopush", out1_valid, 1'b0);

        // No conflict.
        drive(1'b1, 1'b1, 4'hA, 1'b1, 1'b0, 4'h5);
        tick();
        idle();
        tick();
        chk1("nc_ctrl", xb_control, 1'b1);
        chk4("nc_in1", xb_in1, 4'hA);
        chk4("nc_in2", xb_in2, 4'h5);
        chk1("nc_v1", out1_valid, 1'b1);
        chk1("nc_v2", out2_valid, 1'b1);

        // Conflict round robin.
        drive(1'b1, 1'b0, 4'h3, 1'b1, 1'b0, 4'hC);
        tick();
        drive(1'b1, 1'b0, 4'h4, 1'b1, 1'b0, 4'hD);
        tick();
        chk4("rr0_in1", xb_in1, 4'h3); chk4("rr0_in2", xb_in2, 4'h0);
        chk1("rr0_v1", out1_valid, 1'b1); chk1("rr0_v2", out2_valid, 1'b0);
        idle();
        tick();
        chk4("rr1_in1", xb_in1, 4'h0); chk4("rr1_in2", xb_in2, 4'hC);
        chk1("rr1_v1", out1_valid, 1'b1); chk1("rr1_v2", out2_valid, 1'b0);
        tick();
        chk4("rr2_in1", xb_in1, 4'h4); chk4("rr2_in2", xb_in2, 4'h0);
        chk1("rr2_v1", out1_valid, 1'b1); chk1("rr2_v2", out2_valid, 1'b0);
        tick();
        chk4("rr3_in1", xb_in1, 4'h0); chk4("rr3_in2", xb_in2, 4'hD);
        chk1("rr3_v1", out1_valid, 1'b1); chk1("rr3_v2", out2_valid, 1'b0);

        // Single source.
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h7);
        tick();
        idle();
        tick();
        chk1("ss_ctrl", xb_control, 1'b0);
        chk4("ss_in2", xb_in2, 4'h7);
        chk1("ss_v2", out2_valid, 1'b1);
        chk1("ss_v1", out1_valid, 1'b0);

        // Both sources streaming to out1 until the FIFOs back up.
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1'b0, 4'($urandom), 1'b1, 1'b0, 4'($urandom));
        end
        idle();
        for (int i = 0; i < 12; i++) tick();
        chk1("full_seen", saw_full, 1'b1);
        chki("no_loss", n_dut_grants, n_acc);

        // Mid-traffic reset.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 4'($urandom), 1'b1, 1'b0, 4'($urandom));
        end
        @(negedge clk);
        rst = 1'b1; s1_valid = 1'b0; s2_valid = 1'b0;
        tick();
        chk1("mr_v1", out1_valid, 1'b0);
        chk1("mr_v2", out2_valid, 1'b0);
        chk1("mr_rdy1", s1_ready, 1'b1);
        chk1("mr_rdy2", s2_ready, 1'b1);
`ifdef XBAR_SCHED_STATS_EN
        chk8("mr_cc", conflict_cnt, 8'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk1("mr_stale_v1", out1_valid, 1'b0);
        chk4("mr_stale_in1", xb_in1, 4'h0);
        drive(1'b1, 1'b1, 4'hE, 1'b1, 1'b1, 4'hF);
        tick();
        idle();
        tick();
        chk4("mr_prio_in1", xb_in1, 4'hE);
        chk4("mr_prio_in2", xb_in2, 4'h0);
        chk1("mr_prio_ctrl", xb_control, 1'b1);
        chk1("mr_prio_v2", out2_valid, 1'b1);
        tick();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst      = ($urandom_range(49) == 0);
            s1_valid = ($urandom_range(3) != 0);
            s1_dest  = 1'($urandom);
            s1_data  = 4'($urandom);
            s2_valid = ($urandom_range(3) != 0);
            s2_dest  = 1'($urandom);
            s2_data  = 4'($urandom);
        end
        @(negedge clk);
        rst = 1'b0;
        idle();
        for (int i = 0; i < 10; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
